// File: rtl/spi_slave_if.sv
// spi_slave_if: pin and word bus of the SPI responder.
//   sclk_in, cs_n_in, mosi_in : SPI pins from the initiator (asynchronous)
//   data_in                   : response word, captured at frame start
//   miso_out                  : serial response, MSB first
//   data_out                  : last correctly received word
//   valid_out / error_out     : one-cycle frame-complete / bad-bit-count pulses
//   busy_out                  : high while a frame is active
// The slave modport is the responder's view; master is the driver's view.
interface spi_slave_if #(
    parameter int SIZE = 40
);
    logic            sclk_in;
    logic            cs_n_in;
    logic            mosi_in;
    logic [SIZE-1:0] data_in;
    logic            miso_out;
    logic [SIZE-1:0] data_out;
    logic            valid_out;
    logic            error_out;
    logic            busy_out;

    modport slave (
        input  sclk_in, cs_n_in, mosi_in, data_in,
        output miso_out, data_out, valid_out, error_out, busy_out
    );

    modport master (
        output sclk_in, cs_n_in, mosi_in, data_in,
        input  miso_out, data_out, valid_out, error_out, busy_out
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI responder oversampling sclk/cs_n/mosi with clk_in.
// Receives one SIZE-bit word per chip-select frame (MSB first) while shifting
// out a SIZE-bit response on miso. Reports a good frame with valid_out and a
// wrong bit count with error_out.
//   clk_in : system clock, at least 8x the SCLK frequency
//   rst_in : asynchronous active-high reset
//   bus    : spi_slave_if.slave (pins, response word, received word, status)
module spi_slave #(
    parameter int SIZE     = 40,
    parameter int CNT_SIZE = 7
) (
    input  logic        clk_in,
    input  logic        rst_in,
    spi_slave_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CNT_SIZE-1:0] CNT_ONE  = CNT_SIZE'(1);
    localparam logic [CNT_SIZE-1:0] CNT_FULL = CNT_SIZE'(SIZE);
    localparam logic [CNT_SIZE-1:0] CNT_OVER = CNT_SIZE'(SIZE + 1);

    state_t              state;
    logic [1:0]          sclk_sync;
    logic [1:0]          cs_sync;
    logic [2:0]          mosi_sync;
    logic                sclk_prev;
    logic                cs_prev;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                cs_rise;
    logic                cs_fall;
    logic [CNT_SIZE-1:0] bit_cnt;
    logic [SIZE-1:0]     tx_shift;
    logic [SIZE-1:0]     rx_shift;
    logic                miso_r;
    logic [SIZE-1:0]     data_r;
    logic                valid_r;
    logic                error_r;
    logic                busy_r;

    // Two-flop synchronizers, then a registered edge detector. mosi carries a
    // third stage so the bit used on a rise strobe was on the pin together
    // with that SCLK rising edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk_in};
            cs_sync   <= {cs_sync[0], bus.cs_n_in};
            mosi_sync <= {mosi_sync[1:0], bus.mosi_in};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
            sclk_rise <= sclk_sync[1] & ~sclk_prev;
            sclk_fall <= ~sclk_sync[1] & sclk_prev;
            cs_rise   <= cs_sync[1] & ~cs_prev;
            cs_fall   <= ~cs_sync[1] & cs_prev;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            miso_r   <= 1'b0;
            data_r   <= '0;
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            error_r <= 1'b0;
            case (state)
                IDLE: begin
                    miso_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    bit_cnt <= '0;
                    // SCLK strobes coinciding with frame start are dropped.
                    if (cs_fall) begin
                        tx_shift <= bus.data_in;
                        miso_r   <= bus.data_in[SIZE-1];
                        rx_shift <= '0;
                        busy_r   <= 1'b1;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // Frame end wins over any SCLK strobe in the same cycle.
                        if (bit_cnt == CNT_FULL) begin
                            data_r  <= rx_shift;
                            valid_r <= 1'b1;
                        end else begin
                            error_r <= 1'b1;
                        end
                        miso_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[SIZE-2:0], mosi_sync[2]};
                        if (bit_cnt != CNT_OVER)
                            bit_cnt <= bit_cnt + CNT_ONE;
                    end else if (sclk_fall && (bit_cnt != '0) && (bit_cnt < CNT_FULL)) begin
                        // Leading fall (count 0) is skipped: the MSB is already out.
                        tx_shift <= {tx_shift[SIZE-2:0], 1'b0};
                        miso_r   <= tx_shift[SIZE-2];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso_out  = miso_r;
    assign bus.data_out  = data_r;
    assign bus.valid_out = valid_r;
    assign bus.error_out = error_r;
    assign bus.busy_out  = busy_r;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives one SPI pin set into an 8-bit and a 40-bit responder.
// Each frame's expected outcome per responder (valid word or error, data_out,
// pulse cycle) is pushed to a queue at cs_n rise; monitors pop on each pulse.
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        bit          is_valid;
        logic [39:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        q8[$];
    exp_t        q40[$];
    logic [39:0] last8 = '0;
    logic [39:0] last40 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_slave_if #(.SIZE(8))  if8();
    spi_slave_if #(.SIZE(40)) if40();

    assign if8.sclk_in  = sclk;
    assign if8.cs_n_in  = cs_n;
    assign if8.mosi_in  = mosi;
    assign if40.sclk_in = sclk;
    assign if40.cs_n_in = cs_n;
    assign if40.mosi_in = mosi;

    spi_slave #(.SIZE(8), .CNT_SIZE(4)) dut8 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (if8.slave)
    );

    spi_slave #(.SIZE(40), .CNT_SIZE(7)) dut40 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (if40.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input int sel, input logic v, input logic er, input logic [39:0] d);
        exp_t  e;
        string tag;
        tag = (sel == 8) ? "dut8" : "dut40";
        if ((sel == 8) ? (q8.size() == 0) : (q40.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL %s unexpected pulse: valid=%0b error=%0b, expected none (cycle %0d)",
                     tag, v, er, cyc);
        end else begin
            e = (sel == 8) ? q8.pop_front() : q40.pop_front();
            check({tag, " pulse kind {valid,error}"}, {v, er}, {e.is_valid, ~e.is_valid});
            check({tag, " data_out"}, d, e.data);
            check({tag, " pulse cycle"}, cyc, e.cyc + 4);
        end
    endtask

    always @(negedge clk) begin
        if (if8.valid_out === 1'b1 || if8.error_out === 1'b1)
            mon(8, if8.valid_out, if8.error_out, 40'(if8.data_out));
        if (if40.valid_out === 1'b1 || if40.error_out === 1'b1)
            mon(40, if40.valid_out, if40.error_out, if40.data_out);
    end

    // Called #1 after a posedge; returns #1 after posedge number n.
    task automatic to_cycle(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int unsigned h, output logic m8, output logic m40);
        int unsigned t;
        t = cyc;
        sclk = 1'b0;
        mosi = b;
        to_cycle(t + h);
        m8  = if8.miso_out;
        m40 = if40.miso_out;
        sclk = 1'b1;
        to_cycle(t + 2 * h);
    endtask

    task automatic frame(input int unsigned n, input logic [47:0] word, input logic [7:0] d8,
                         input logic [39:0] d40, input int unsigned h, input int unsigned gap);
        logic [7:0]  cap8;
        logic [39:0] cap40;
        logic        m8, m40;
        int unsigned t, rise, k8, k40;
        if8.data_in  = d8;
        if40.data_in = d40;
        cap8  = '0;
        cap40 = '0;
        t = cyc;
        cs_n = 1'b0;
        do @(negedge clk); while (cyc < t + 3);
        check("dut8 busy 3 cycles after cs fall", if8.busy_out, 0);
        check("dut40 busy 3 cycles after cs fall", if40.busy_out, 0);
        do @(negedge clk); while (cyc < t + 4);
        check("dut8 busy 4 cycles after cs fall", if8.busy_out, 1);
        check("dut40 busy 4 cycles after cs fall", if40.busy_out, 1);
        to_cycle(t + h);
        for (int unsigned i = 0; i < n; i++) begin
            send_bit(word[n - 1 - i], h, m8, m40);
            if (i < 8)  cap8  = {cap8[6:0], m8};
            if (i < 40) cap40 = {cap40[38:0], m40};
        end
        t = cyc;
        to_cycle(t + h);
        cs_n = 1'b1;
        rise = cyc;
        if (n == 8) begin
            last8 = 40'(word[7:0]);
            q8.push_back('{1'b1, last8, rise});
        end else begin
            q8.push_back('{1'b0, last8, rise});
        end
        if (n == 40) begin
            last40 = word[39:0];
            q40.push_back('{1'b1, last40, rise});
        end else begin
            q40.push_back('{1'b0, last40, rise});
        end
        k8  = (n < 8) ? n : 8;
        k40 = (n < 40) ? n : 40;
        check("dut8 miso bits at sclk rise", cap8, 64'(d8) >> (8 - k8));
        check("dut40 miso bits at sclk rise", cap40, 64'(d40) >> (40 - k40));
        mosi = 1'b0;
        to_cycle(rise + gap);
    endtask

    task automatic check_zero(input string when_s);
        check({"dut8 outputs ", when_s},
              {if8.miso_out, if8.valid_out, if8.error_out, if8.busy_out, if8.data_out}, 0);
        check({"dut40 outputs ", when_s},
              {if40.miso_out, if40.valid_out, if40.error_out, if40.busy_out, if40.data_out}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  rnd;
        logic         m8, m40;
        int unsigned  t, n, sel;
        if8.data_in  = '0;
        if40.data_in = '0;
        to_cycle(3);
        check_zero("during reset");
        rst = 1'b0;
        to_cycle(cyc + 5);
        check_zero("after reset");

        frame(8, 48'hA5, 8'h3C, 40'h87_6543_2101, 8, 4);
        frame(40, 48'h12_3456_789A, 8'h5A, 40'hC3_0F0F_55AA, 6, 4);
        frame(40, 48'hFF_0000_FF00, 8'h81, 40'h01_2345_6789, 6, 4);
        frame(5, 48'h15, 8'hE7, 40'hF0_F0F0_F0F0, 8, 6);
        frame(9, 48'h1C3, 8'h96, 40'h80_0000_0001, 8, 6);

        // Reset after bit 3 of a frame, then release with cs_n still low.
        cs_n = 1'b0;
        t = cyc;
        to_cycle(t + 8);
        for (int i = 0; i < 3; i++) send_bit(i[0], 8, m8, m40);
        rst = 1'b1;
        #1;
        check_zero("right after mid-frame reset");
        last8  = '0;
        last40 = '0;
        to_cycle(cyc + 3);
        rst = 1'b0;
        t = cyc;
        to_cycle(t + 8);
        for (int i = 0; i < 3; i++) send_bit(~i[0], 8, m8, m40);
        t = cyc;
        to_cycle(t + 8);
        cs_n = 1'b1;
        q8.push_back('{1'b0, last8, cyc});
        q40.push_back('{1'b0, last40, cyc});
        to_cycle(cyc + 6);

        frame(8, 48'h6E, 8'h42, 40'h00_FFFF_0000, 7, 4);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       n = 8;
                1:       n = 40;
                2:       n = $urandom_range(1, 47);
                default: n = $urandom_range(1, 12);
            endcase
            rnd = {$urandom, $urandom};
            frame(n, rnd[47:0], 8'($urandom), {8'($urandom), 32'($urandom)},
                  $urandom_range(5, 10), $urandom_range(4, 8));
        end

        to_cycle(cyc + 20);
        check("dut8 unconsumed expectations", q8.size(), 0);
        check("dut40 unconsumed expectations", q40.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
